// File: rtl/tilemap_port_arbiter_pkg.sv
// Shared types and constants for the tile-map RAM port arbiter: map geometry,
// default widths and the writer-drain FSM state encoding.
package tilemap_pkg;

    localparam int TILES_X     = 60;
    localparam int TILES_Y     = 34;
    localparam int TILE_COUNT  = TILES_X * TILES_Y;

    localparam int ADDR_W_DEF      = 11;
    localparam int DATA_W_DEF      = 8;
    localparam int WFIFO_DEPTH_DEF = 8;
    localparam int STALL_W_DEF     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/tilemap_port_arbiter_if.sv
// Bundle of scanout, writer and RAM-port signals around the tile-map arbiter.
// slave is the arbiter's view; master is the view of whatever surrounds it.
interface tilemap_port_arbiter_if #(
    parameter int ADDR_W  = tilemap_pkg::ADDR_W_DEF,
    parameter int DATA_W  = tilemap_pkg::DATA_W_DEF,
    parameter int STALL_W = tilemap_pkg::STALL_W_DEF
);

    logic               in_scan_req;
    logic [ADDR_W-1:0]  in_scan_addr;
    logic [DATA_W-1:0]  out_scan_data;
    logic               out_scan_valid;
    logic               in_blank;
    logic               in_wr_valid;
    logic [ADDR_W-1:0]  in_wr_addr;
    logic [DATA_W-1:0]  in_wr_data;
    logic               out_wr_ready;
    logic               out_mem_en;
    logic               out_mem_we;
    logic [ADDR_W-1:0]  out_mem_addr;
    logic [DATA_W-1:0]  out_mem_wdata;
    logic [DATA_W-1:0]  in_mem_rdata;
    logic               out_busy;
    logic [STALL_W-1:0] out_stall_cnt;

    modport slave (
        input  in_scan_req, in_scan_addr, in_blank,
        input  in_wr_valid, in_wr_addr, in_wr_data, in_mem_rdata,
        output out_scan_data, out_scan_valid, out_wr_ready,
        output out_mem_en, out_mem_we, out_mem_addr, out_mem_wdata,
        output out_busy, out_stall_cnt
    );

    modport master (
        output in_scan_req, in_scan_addr, in_blank,
        output in_wr_valid, in_wr_addr, in_wr_data, in_mem_rdata,
        input  out_scan_data, out_scan_valid, out_wr_ready,
        input  out_mem_en, out_mem_we, out_mem_addr, out_mem_wdata,
        input  out_busy, out_stall_cnt
    );

endinterface

// File: rtl/tilemap_port_arbiter_sync_fifo.sv
// Single-clock FIFO for buffered tile-map writes. Pointers carry one extra MSB
// so full and empty are distinguishable; full/empty/ready are registered.
module sync_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       ready_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             full_q;
    logic             empty_q;
    logic             ready_q;
    logic             push_ok_s;
    logic             pop_ok_s;
    logic [AW:0]      count_s;
    logic [AW:0]      count_d;

    assign push_ok_s = push_i & ~full_q;
    assign pop_ok_s  = pop_i & ~empty_q;
    assign count_s   = wptr_q - rptr_q;
    assign count_d   = count_s + {{AW{1'b0}}, push_ok_s} - {{AW{1'b0}}, pop_ok_s};

    assign data_o  = mem_q[rptr_q[AW-1:0]];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign ready_o = ready_q;
    assign count_o = count_s;

    // Storage array; contents are meaningless while the pointers say empty.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_q[wptr_q[AW-1:0]] <= data_i;
        end
    end

    // Pointer advance and registered occupancy flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= {(AW + 1){1'b0}};
            rptr_q  <= {(AW + 1){1'b0}};
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ready_q <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wptr_q <= wptr_q + PTR_ONE;
            end
            if (pop_ok_s) begin
                rptr_q <= rptr_q + PTR_ONE;
            end
            full_q  <= (count_d == FULL_CNT);
            empty_q <= (count_d == {(AW + 1){1'b0}});
            ready_q <= (count_d != FULL_CNT);
        end
    end

endmodule

// File: rtl/tilemap_port_arbiter.sv
// Shares the single-port tile-map RAM between scanout reads (strict priority,
// fixed 2-cycle latency) and FIFO-buffered writer traffic drained into idle slots.
// Define TILEMAP_ARB_BLANK_ONLY_EN to restrict writes to blanking (tear-free).
module tilemap_port_arbiter
    import tilemap_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WFIFO_DEPTH = WFIFO_DEPTH_DEF,
    parameter int STALL_W     = STALL_W_DEF
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    tilemap_port_arbiter_if.slave   bus
);

    localparam int FW = ADDR_W + DATA_W;
    localparam int AW = $clog2(WFIFO_DEPTH);
    localparam logic [AW:0] ONE_ENTRY = {{AW{1'b0}}, 1'b1};

    arb_state_e         state_q;
    logic               mem_en_q,    mem_en_d;
    logic               mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               scan_valid_q;
    logic [STALL_W-1:0] stall_q;

    logic               push_s;
    logic               pop_s;
    logic               gate_open_s;
    logic [FW-1:0]      head_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               wr_ready_s;
    logic [AW:0]        fifo_count_s;

`ifdef TILEMAP_ARB_BLANK_ONLY_EN
    assign gate_open_s = bus.in_blank;
`else
    assign gate_open_s = 1'b1;
`endif

    assign push_s = bus.in_wr_valid & wr_ready_s & ~fifo_full_s;
    assign pop_s  = (state_q == ST_DRAIN) & ~fifo_empty_s & ~bus.in_scan_req & gate_open_s;

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (WFIFO_DEPTH)
    ) u_wfifo (
        .clk_i   (in_clk),
        .rst_i   (in_rst),
        .push_i  (push_s),
        .data_i  ({bus.in_wr_addr, bus.in_wr_data}),
        .pop_i   (pop_s),
        .data_o  (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .ready_o (wr_ready_s),
        .count_o (fifo_count_s)
    );

    // RAM port mux: scanout wins, a drain pop takes the slot otherwise.
    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (bus.in_scan_req) begin
            mem_en_d   = 1'b1;
            mem_addr_d = bus.in_scan_addr;
        end else if (pop_s) begin
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = head_s[DATA_W +: ADDR_W];
            mem_wdata_d = head_s[DATA_W-1:0];
        end else begin
            mem_en_d = 1'b0;
        end
    end

    // Drain FSM, registered RAM port, scan-valid pipeline and stall counter.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q      <= ST_IDLE;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {ADDR_W{1'b0}};
            mem_wdata_q  <= {DATA_W{1'b0}};
            scan_valid_q <= 1'b0;
            stall_q      <= {STALL_W{1'b0}};
        end else begin
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            // A read issued on the port last cycle returns RAM data this cycle.
            scan_valid_q <= mem_en_q & ~mem_we_q;

            if (bus.in_wr_valid && !wr_ready_s && (stall_q != {STALL_W{1'b1}})) begin
                stall_q <= stall_q + {{(STALL_W-1){1'b0}}, 1'b1};
            end else begin
                stall_q <= stall_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (push_s) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (!gate_open_s) begin
                        state_q <= ST_HOLD;
                    end else if (pop_s && (fifo_count_s == ONE_ENTRY) && !push_s) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_HOLD: begin
                    if (gate_open_s) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        state_q <= ST_HOLD;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Read data comes straight from the RAM so the 2-cycle latency holds.
    assign bus.out_scan_data  = scan_valid_q ? bus.in_mem_rdata : {DATA_W{1'b0}};
    assign bus.out_scan_valid = scan_valid_q;
    assign bus.out_wr_ready   = wr_ready_s;
    assign bus.out_mem_en     = mem_en_q;
    assign bus.out_mem_we     = mem_we_q;
    assign bus.out_mem_addr   = mem_addr_q;
    assign bus.out_mem_wdata  = mem_wdata_q;
    assign bus.out_busy       = (state_q != ST_IDLE);
    assign bus.out_stall_cnt  = stall_q;

endmodule

// File: tb/tb_tilemap_port_arbiter.sv
// Directed bench for tilemap_port_arbiter with a behavioural 1-cycle RAM.
module tb_tilemap_port_arbiter;

    localparam int ADDR_W  = 11;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 8;
    localparam int STALL_W = 3;
`ifdef TILEMAP_ARB_BLANK_ONLY_EN
    localparam logic BLANK_DEF = 1'b1;
`else
    localparam logic BLANK_DEF = 1'b0;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [31:0]       c;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       cyc = 32'd0;
    logic              pre_we = 1'b0;
    logic [ADDR_W-1:0] pre_addr = 11'd0;
    logic [DATA_W-1:0] pre_data = 8'd0;
    logic [DATA_W-1:0] ram [0:2047];
    logic [DATA_W-1:0] ram_rdata_q = 8'd0;
    wr_t               wlog[$];
    int                errors = 0;
    int                checks = 0;

    always #5 clk = ~clk;

    tilemap_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STALL_W(STALL_W)) bus ();

    tilemap_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WFIFO_DEPTH(DEPTH), .STALL_W(STALL_W)
    ) dut (
        .in_clk (clk),
        .in_rst (rst),
        .bus    (bus.slave)
    );

    // RAM model with a preload port, plus a log of every write seen on the port.
    always @(posedge clk) begin
        cyc <= cyc + 32'd1;
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (bus.out_mem_en && bus.out_mem_we) ram[bus.out_mem_addr] <= bus.out_mem_wdata;
        if (bus.out_mem_en && !bus.out_mem_we) ram_rdata_q <= ram[bus.out_mem_addr];
        if (bus.out_mem_en && bus.out_mem_we) wlog.push_back({bus.out_mem_addr, bus.out_mem_wdata, cyc});
    end
    assign bus.in_mem_rdata = ram_rdata_q;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        step();
        pre_we = 1'b0;
    endtask

    task automatic scan_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d, output logic v);
        bus.in_scan_req = 1'b1; bus.in_scan_addr = a;
        step();
        bus.in_scan_req = 1'b0;
        step();
        d = bus.out_scan_data; v = bus.out_scan_valid;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (!bus.out_busy) begin ok = 1'b1; break; end
            step();
        end
        step();
    endtask

    task automatic test_reset();
        logic [34:0] v;
        bus.in_scan_req = 1'b0; bus.in_scan_addr = 11'd0; bus.in_blank = BLANK_DEF;
        bus.in_wr_valid = 1'b1; bus.in_wr_addr = 11'd5; bus.in_wr_data = 8'h11;
        rst = 1'b1;
        repeat (3) step();
        v = {bus.out_scan_data, bus.out_scan_valid, bus.out_wr_ready, bus.out_mem_en, bus.out_mem_we,
             bus.out_mem_addr, bus.out_mem_wdata, bus.out_busy, bus.out_stall_cnt};
        checks++;
        if (v !== 35'd0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", v); end
        bus.in_wr_valid = 1'b0;
        rst = 1'b0;
        step();
        checks++;
        if ({bus.out_wr_ready, bus.out_busy, bus.out_mem_en} !== 3'b100) begin
            errors++; $display("FAIL post_reset ready/busy/en: got %b expected 100",
                               {bus.out_wr_ready, bus.out_busy, bus.out_mem_en});
        end
        step();
        checks++;
        if (wlog.size() != 0 || bus.out_stall_cnt !== 3'd0) begin
            errors++; $display("FAIL post_reset_fifo_empty: writes %0d stall %0d expected 0 0",
                               wlog.size(), bus.out_stall_cnt);
        end
    endtask

    task automatic test_scan_only();
        preload(11'h123, 8'h5A);
        bus.in_scan_req = 1'b1; bus.in_scan_addr = 11'h123;
        step();
        bus.in_scan_req = 1'b0;
        checks++;
        if ({bus.out_mem_en, bus.out_mem_we, bus.out_mem_addr} !== {1'b1, 1'b0, 11'h123}) begin
            errors++; $display("FAIL scan_port N+1: en %b we %b addr %h expected 1 0 123",
                               bus.out_mem_en, bus.out_mem_we, bus.out_mem_addr);
        end
        checks++;
        if (bus.out_scan_valid !== 1'b0) begin errors++; $display("FAIL scan_valid_early: got %b expected 0", bus.out_scan_valid); end
        step();
        checks++;
        if ({bus.out_scan_valid, bus.out_scan_data} !== {1'b1, 8'h5A}) begin
            errors++; $display("FAIL scan_data N+2: valid %b data %h expected 1 5a", bus.out_scan_valid, bus.out_scan_data);
        end
        step();
        checks++;
        if (bus.out_scan_valid !== 1'b0) begin errors++; $display("FAIL scan_valid_pulse: got %b expected 0", bus.out_scan_valid); end
    endtask

    task automatic test_contention();
        int bad_we = 0;
        logic [DATA_W-1:0] d;
        logic v;
        logic [DATA_W-1:0] mid_d = 8'd0;
        logic mid_v = 1'b0;
        preload(11'd7, 8'h01);
        bus.in_scan_req = 1'b1; bus.in_scan_addr = 11'd100;
        bus.in_wr_valid = 1'b1; bus.in_wr_addr = 11'd7; bus.in_wr_data = 8'h33;
        for (int i = 1; i <= 10; i++) begin
            step();
            bus.in_wr_valid = 1'b0;
            if (bus.out_mem_we !== 1'b0) bad_we++;
            if (i == 7) begin mid_d = bus.out_scan_data; mid_v = bus.out_scan_valid; end
            if (i < 10) begin
                bus.in_scan_req = 1'b1;
                bus.in_scan_addr = (i == 5) ? 11'd7 : 11'(100 + i);
            end else begin
                bus.in_scan_req = 1'b0;
            end
        end
        checks++;
        if (bad_we != 0) begin errors++; $display("FAIL contention_no_write: writes %0d expected 0", bad_we); end
        checks++;
        if ({mid_v, mid_d} !== {1'b1, 8'h01}) begin
            errors++; $display("FAIL no_forwarding: valid %b data %h expected 1 01", mid_v, mid_d);
        end
        step();
        checks++;
        if ({bus.out_mem_en, bus.out_mem_we, bus.out_mem_addr, bus.out_mem_wdata} !== {1'b1, 1'b1, 11'd7, 8'h33}) begin
            errors++; $display("FAIL first_free_write: en %b we %b addr %h data %h expected 1 1 007 33",
                               bus.out_mem_en, bus.out_mem_we, bus.out_mem_addr, bus.out_mem_wdata);
        end
        step();
        scan_read(11'd7, d, v);
        checks++;
        if ({v, d} !== {1'b1, 8'h33}) begin errors++; $display("FAIL readback_7: valid %b data %h expected 1 33", v, d); end
    endtask

    task automatic test_full_stall();
        int bad = 0;
        int base;
        bit ok;
        base = wlog.size();
        bus.in_scan_req = 1'b1; bus.in_scan_addr = 11'd300;
        for (int i = 0; i < 8; i++) begin
            bus.in_wr_valid = 1'b1; bus.in_wr_addr = 11'(200 + i); bus.in_wr_data = 8'(8'h80 + i);
            if (bus.out_wr_ready !== 1'b1) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL fill_ready: not-ready cycles %0d expected 0", bad); end
        checks++;
        if (bus.out_wr_ready !== 1'b0) begin errors++; $display("FAIL ready_after_8: got %b expected 0", bus.out_wr_ready); end
        bus.in_wr_addr = 11'd208; bus.in_wr_data = 8'h88;
        repeat (5) step();
        checks++;
        if (bus.out_stall_cnt !== 3'd5 || wlog.size() != base) begin
            errors++; $display("FAIL stall_5: stall %0d writes %0d expected 5 0", bus.out_stall_cnt, wlog.size() - base);
        end
        bus.in_scan_req = 1'b0;
        step();
        checks++;
        if ({bus.out_wr_ready, bus.out_mem_we, bus.out_mem_addr, bus.out_mem_wdata} !== {1'b1, 1'b1, 11'd200, 8'h80}) begin
            errors++; $display("FAIL first_pop: ready %b we %b addr %h data %h expected 1 1 0c8 80",
                               bus.out_wr_ready, bus.out_mem_we, bus.out_mem_addr, bus.out_mem_wdata);
        end
        step();
        bus.in_wr_valid = 1'b0;
        checks++;
        if (bus.out_stall_cnt !== 3'd6) begin errors++; $display("FAIL stall_final: got %0d expected 6", bus.out_stall_cnt); end
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL drain_timeout_full: busy still %b expected 0", bus.out_busy); end
        bad = 0;
        if (wlog.size() != base + 9) bad = 1;
        else for (int i = 0; i < 9; i++)
            if (wlog[base + i].a !== 11'(200 + i) || wlog[base + i].d !== 8'(8'h80 + i)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL full_order: writes %0d bad %0d expected 9 0", wlog.size() - base, bad); end
    endtask

    task automatic test_stall_saturate();
        bit ok;
        bus.in_scan_req = 1'b1; bus.in_scan_addr = 11'd301;
        for (int i = 0; i < 8; i++) begin
            bus.in_wr_valid = 1'b1; bus.in_wr_addr = 11'(400 + i); bus.in_wr_data = 8'(8'h40 + i);
            step();
        end
        repeat (4) step();
        bus.in_wr_valid = 1'b0;
        checks++;
        if (bus.out_stall_cnt !== 3'd7) begin errors++; $display("FAIL stall_saturate: got %0d expected 7", bus.out_stall_cnt); end
        bus.in_scan_req = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok || bus.out_stall_cnt !== 3'd7) begin
            errors++; $display("FAIL stall_hold: idle %b stall %0d expected 1 7", ok, bus.out_stall_cnt);
        end
    endtask

    task automatic test_order_wrap();
        int bad = 0;
        int base;
        logic [DATA_W-1:0] d;
        logic v;
        base = wlog.size();
        bus.in_scan_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.in_wr_valid = 1'b1; bus.in_wr_addr = 11'(i); bus.in_wr_data = 8'(8'hA0 + i);
            if (bus.out_wr_ready !== 1'b1) bad++;
            step();
        end
        bus.in_wr_valid = 1'b0;
        checks++;
        if (bad != 0 || bus.out_busy !== 1'b1) begin
            errors++; $display("FAIL order_push: not-ready %0d busy %b expected 0 1", bad, bus.out_busy);
        end
        step();
        checks++;
        if ({bus.out_busy, bus.out_mem_we, bus.out_mem_addr, bus.out_mem_wdata} !== {1'b0, 1'b1, 11'd19, 8'hB3}) begin
            errors++; $display("FAIL busy_fall: busy %b we %b addr %h data %h expected 0 1 013 b3",
                               bus.out_busy, bus.out_mem_we, bus.out_mem_addr, bus.out_mem_wdata);
        end
        step();
        bad = 0;
        if (wlog.size() != base + 20) bad = 1;
        else for (int i = 0; i < 20; i++)
            if (wlog[base + i].a !== 11'(i) || wlog[base + i].d !== 8'(8'hA0 + i)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL order_commit: writes %0d bad %0d expected 20 0", wlog.size() - base, bad); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            scan_read(11'(i), d, v);
            if ({v, d} !== {1'b1, 8'(8'hA0 + i)}) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL order_readback: bad %0d expected 0", bad); end
    endtask

    task automatic test_blank_gating();
        int bad = 0;
        int base;
        logic [31:0] exp_c;
        bit ok;
        base = wlog.size();
        bus.in_blank = 1'b0; bus.in_scan_req = 1'b0;
        exp_c = cyc + 32'd2;
        for (int i = 0; i < 3; i++) begin
            bus.in_wr_valid = 1'b1; bus.in_wr_addr = 11'(500 + i); bus.in_wr_data = 8'(8'h50 + i);
            step();
        end
        bus.in_wr_valid = 1'b0;
`ifdef TILEMAP_ARB_BLANK_ONLY_EN
        repeat (4) begin
            step();
            if (bus.out_mem_we !== 1'b0 || bus.out_busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0 || wlog.size() != base) begin
            errors++; $display("FAIL hold_no_write: bad %0d writes %0d expected 0 0", bad, wlog.size() - base);
        end
        exp_c = cyc + 32'd2;
        bus.in_blank = 1'b1;
`endif
        wait_idle(ok);
        bad = 0;
        if (!ok || wlog.size() != base + 3) bad = 1;
        else for (int i = 0; i < 3; i++)
            if (wlog[base + i].a !== 11'(500 + i) || wlog[base + i].d !== 8'(8'h50 + i) ||
                wlog[base + i].c !== exp_c + 32'(i)) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL gated_writes: idle %b writes %0d bad %0d expected 1 3 0", ok, wlog.size() - base, bad);
        end
        bus.in_blank = BLANK_DEF;
    endtask

    initial begin
        test_reset();
        test_scan_only();
        test_contention();
        test_full_stall();
        test_stall_saturate();
        test_order_wrap();
        test_blank_gating();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
